// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton front end: channel map and default timing.
package btn_pkg;

  localparam int NUM_BTN = 6;

  localparam int BTN_RST1 = 0;
  localparam int BTN_RST2 = 1;
  localparam int BTN_ADD1 = 2;
  localparam int BTN_ADD2 = 3;
  localparam int BTN_ADD3 = 4;
  localparam int BTN_ADD4 = 5;

  localparam int DB_CYCLES_DEF     = 16;
  localparam int REPEAT_DELAY_DEF  = 200;
  localparam int REPEAT_PERIOD_DEF = 50;

  // Only the add buttons auto-repeat; the reset buttons never do.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEF = 6'b111100;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, stable-count debounce and press event.
// Auto-repeat counter exists only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
`ifdef BTN_REPEAT_EN
  parameter bit RPT_EN        = 1'b0,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
`endif
  parameter int CNT_W = $clog2(DB_CYCLES) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic event_o
);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_lim;
  logic             rpt_arm_q, rpt_arm_d;
  logic             rpt_fire;

  // Counter runs only while the level stays high; the press edge and release both clear it.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_arm_d = 1'b0;
    rpt_fire  = 1'b0;
    rpt_lim   = rpt_arm_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    if (RPT_EN && level_q && level_d) begin
      if (rpt_cnt_q == rpt_lim) begin
        rpt_fire  = 1'b1;
        rpt_arm_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        rpt_arm_d = rpt_arm_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end

  assign event_o = rise | rpt_fire;
`else
  assign event_o = rise;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Debounces six pushbuttons and issues at most one registered press pulse per cycle, lowest index first.
// Optional auto-repeat on held buttons is compiled in with BTN_REPEAT_EN.
module btn_conditioner #(
  parameter int NUM_BTN   = btn_pkg::NUM_BTN,
  parameter int DB_CYCLES = btn_pkg::DB_CYCLES_DEF,
`ifdef BTN_REPEAT_EN
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = btn_pkg::REPEAT_MASK_DEF,
  parameter int REPEAT_DELAY  = btn_pkg::REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = btn_pkg::REPEAT_PERIOD_DEF,
`endif
  parameter int CNT_W = $clog2(DB_CYCLES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               busy
);

  import btn_pkg::*;

  logic [NUM_BTN-1:0] event_w;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [NUM_BTN-1:0] grant;
  logic               busy_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
`ifdef BTN_REPEAT_EN
      .RPT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .event_o(event_w[i])
    );
  end

  // Lowest set bit wins; a new event ORed in after the clear means a set beats a same-edge clear.
  always_comb begin
    grant     = pending_q & (~pending_q + NUM_BTN'(1));
    pulse_d   = grant;
    pending_d = (pending_q & ~grant) | event_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      pulse_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      busy_q    <= |pending_d;
    end
  end

  assign btn_pulse = pulse_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DB_CYCLES=4) with a per-cycle behavioural model.
module tb_btn_conditioner;

  localparam int NB = 6;
  localparam int DB = 4;
`ifdef BTN_REPEAT_EN
  localparam int RD = 10;
  localparam int RP = 5;
  localparam logic [NB-1:0] RMASK = 6'b111100;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_level;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN      (NB),
`ifdef BTN_REPEAT_EN
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
`endif
    .DB_CYCLES    (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .busy     (busy)
  );

  // Model: level flips once the last DB synchronised samples all disagree with it.
  logic [NB-1:0] rq[$];
  logic [NB-1:0] sq[$];
  logic [NB-1:0] m_level = '0, m_pend = '0, m_pulse = '0;
  logic          m_busy = 1'b0;
  int            age[NB];

  always @(posedge clk) begin
    logic [NB-1:0] s2, ev, grant, nlev;
    bit            all_diff;
    if (rst) begin
      rq.delete();
      sq.delete();
      m_level = '0;
      m_pend  = '0;
      m_pulse = '0;
      m_busy  = 1'b0;
      for (int i = 0; i < NB; i++) age[i] = 0;
    end else begin
      s2 = (rq.size() >= 2) ? rq[rq.size()-2] : '0;
      rq.push_back(btn_raw);
      if (rq.size() > 2) void'(rq.pop_front());
      sq.push_back(s2);
      if (sq.size() > DB) void'(sq.pop_front());
      nlev = m_level;
      ev   = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = (sq.size() == DB);
        foreach (sq[k]) if (sq[k][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) nlev[i] = ~m_level[i];
        if (nlev[i] && !m_level[i]) ev[i] = 1'b1;
`ifdef BTN_REPEAT_EN
        if (!nlev[i] || !m_level[i]) age[i] = 0;
        else if (RMASK[i]) begin
          age[i]++;
          if (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)) ev[i] = 1'b1;
        end
`endif
      end
      grant = '0;
      for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) grant = NB'(1) << i;
      m_pulse = grant;
      m_pend  = (m_pend & ~grant) | ev;
      m_busy  = |m_pend;
      m_level = nlev;
    end
  end

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      expect_eq("model_pulse", 32'(btn_pulse), 32'(m_pulse));
      expect_eq("model_level", 32'(btn_level), 32'(m_level));
      expect_eq("model_busy",  32'(busy),      32'(m_busy));
      expect_eq("pulse_onehot0", 32'($countones(btn_pulse) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int first;
    int offs[$];
    rst     = 1'b1;
    btn_raw = '0;
    tick();
    chk_en = 1'b1;
    tick();
    expect_eq("reset_pulse", 32'(btn_pulse), 32'd0);
    expect_eq("reset_level", 32'(btn_level), 32'd0);
    expect_eq("reset_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    idle(3);

    // Clean press on add1
    btn_raw[2] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) expect_eq("clean_lvl_e5", 32'(btn_level[2]), 32'd0);
      if (e == 6) expect_eq("clean_lvl_e6", 32'(btn_level[2]), 32'd1);
      if (e == 6) expect_eq("clean_pulse_e6", 32'(btn_pulse), 32'd0);
      if (e == 7) expect_eq("clean_pulse_e7", 32'(btn_pulse), 32'h04);
      if (e == 8) expect_eq("clean_pulse_e8", 32'(btn_pulse), 32'd0);
    end
    n = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (btn_pulse != '0) n++;
    end
`ifndef BTN_REPEAT_EN
    expect_eq("clean_no_repeat", 32'(n), 32'd0);
`endif
    btn_raw = '0;
    idle(12);

    // Bounce on add2
    for (int t = 0; t < 4; t++) begin
      btn_raw[3] = (t % 2 == 0);
      tick();
      expect_eq("bounce_lvl", 32'(btn_level[3]), 32'd0);
    end
    btn_raw[3] = 1'b1;
    n = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_pulse[3]) n++;
      if (e == 7) expect_eq("bounce_pulse_e7", 32'(btn_pulse), 32'h08);
    end
    expect_eq("bounce_count", 32'(n), 32'd1);
    btn_raw = '0;
    idle(12);

    // Simultaneous rst1 + add4
    btn_raw = 6'b100001;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 5) expect_eq("simul_busy_e5", 32'(busy), 32'd0);
      if (e == 6) expect_eq("simul_busy_e6", 32'(busy), 32'd1);
      if (e == 7) expect_eq("simul_pulse_e7", 32'(btn_pulse), 32'h01);
      if (e == 7) expect_eq("simul_busy_e7", 32'(busy), 32'd1);
      if (e == 8) expect_eq("simul_pulse_e8", 32'(btn_pulse), 32'h20);
      if (e == 8) expect_eq("simul_busy_e8", 32'(busy), 32'd0);
      if (e == 9) expect_eq("simul_pulse_e9", 32'(btn_pulse), 32'd0);
    end
    btn_raw = '0;
    idle(12);

    // Reset with events pending and a count in progress
    btn_raw = 6'b000111;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 3) btn_raw[4] = 1'b1;
    end
    expect_eq("rstmid_pulse_e7", 32'(btn_pulse), 32'h01);
    rst = 1'b1;
    tick();
    expect_eq("rstmid_pulse", 32'(btn_pulse), 32'd0);
    expect_eq("rstmid_level", 32'(btn_level), 32'd0);
    expect_eq("rstmid_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 6 && btn_pulse != '0) n++;
      if (k == 7)  expect_eq("rstmid_fresh_k7",  32'(btn_pulse), 32'h01);
      if (k == 10) expect_eq("rstmid_fresh_k10", 32'(btn_pulse), 32'h10);
    end
    expect_eq("rstmid_quiet", 32'(n), 32'd0);
    btn_raw = '0;
    idle(12);

    // Three-cycle glitch on rst2
    btn_raw[1] = 1'b1;
    idle(3);
    btn_raw[1] = 1'b0;
    n = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (btn_level[1] || btn_pulse != '0) n++;
    end
    expect_eq("glitch_quiet", 32'(n), 32'd0);

`ifdef BTN_REPEAT_EN
    // Auto-repeat on add3: level stays high for 30 cycles after the press edge
    btn_raw[4] = 1'b1;
    first = -1;
    offs.delete();
    for (int e = 1; e <= 50; e++) begin
      if (e == 32) btn_raw[4] = 1'b0;
      tick();
      if (btn_pulse[4]) begin
        if (first < 0) first = e;
        offs.push_back(e - first);
      end
    end
    expect_eq("rpt_first_e7", 32'(first), 32'd7);
    expect_eq("rpt_count", 32'(offs.size()), 32'd6);
    if (offs.size() == 6) begin
      expect_eq("rpt_off1", 32'(offs[1]), 32'd10);
      expect_eq("rpt_off2", 32'(offs[2]), 32'd15);
      expect_eq("rpt_off5", 32'(offs[5]), 32'd30);
    end
    idle(12);
    btn_raw[0] = 1'b1;
    n = 0;
    for (int e = 0; e < 45; e++) begin
      tick();
      if (btn_pulse[0]) n++;
    end
    expect_eq("rpt_masked_once", 32'(n), 32'd1);
    btn_raw = '0;
    idle(12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
